req_arbiter_4ch: RTL and testbench

- Sequential arbiter that shares one downstream resource among 4 requesters.
- Requests use the same bit-significance as the 4-bit priority encoder: index 3 is highest in fixed mode.
- Adds a selectable round-robin mode, grant locking until release, a hold-time watchdog and a one-cycle dead time between owners.
- Sits in front of any shared combinational datapath and drives its select lines from GNT_ID.

---
 rtl/req_arbiter_4ch.sv | 128 ++++++++++++
 tb/tb_req_arbiter_4ch.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/req_arbiter_4ch.sv
`default_nettype none
// ============================================================================
// Module   : req_arbiter_4ch
// Brief    : 4-requester arbiter, fixed/round-robin, grant lock, hold
//            watchdog and one-cycle dead time between owners.
// Revision : 1.0 - initial release
// ============================================================================
module req_arbiter_4ch #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] REQ,
    input  logic       RR_MODE,
    input  logic       DONE,
    output logic [3:0] GNT,
    output logic [1:0] GNT_ID,
    output logic       BUSY,
    output logic       TIMEOUT
);

    localparam int CNT_W = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] c_max_hold = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [3:0]       r_gnt, w_gnt_nxt;
    logic [1:0]       r_gnt_id, w_id_nxt;
    logic [1:0]       r_last_id, w_last_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_timeout, w_to_nxt;

    logic [1:0]       w_win_fixed, w_win_rr, w_win, w_start, w_idx;
    logic             w_owner_req, w_expire, w_release;

    // Winner selection: fixed picks the highest index, RR the first set bit
    // at or after the slot following the previous owner.
    always_comb begin
        w_win_fixed = 2'd0;
        w_win_rr    = 2'd0;
        w_idx       = 2'd0;
        w_start     = r_last_id + 2'd1;
        for (int i = 0; i < 4; i++) begin
            if (REQ[i]) w_win_fixed = 2'(i);
        end
        for (int i = 3; i >= 0; i--) begin
            w_idx = w_start + 2'(i);
            if (REQ[w_idx]) w_win_rr = w_idx;
        end
        w_win = RR_MODE ? w_win_rr : w_win_fixed;
    end

    assign w_owner_req = REQ[r_gnt_id];
    assign w_expire    = (r_cnt == c_max_hold);
    assign w_release   = DONE || !w_owner_req || w_expire;

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_id_nxt    = r_gnt_id;
        w_last_nxt  = r_last_id;
        w_cnt_nxt   = r_cnt;
        w_to_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|REQ) begin
                    w_gnt_nxt   = 4'b0001 << w_win;
                    w_id_nxt    = w_win;
                    w_cnt_nxt   = c_one;
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (w_release) begin
                    w_gnt_nxt   = 4'b0000;
                    w_id_nxt    = 2'd0;
                    w_cnt_nxt   = '0;
                    w_last_nxt  = r_gnt_id;
                    w_state_nxt = ST_GAP;
                    // Only a pure watchdog expiry is reported as a timeout.
                    w_to_nxt    = w_expire && !DONE && w_owner_req;
                end else begin
                    w_cnt_nxt   = r_cnt + c_one;
                end
            end
            ST_GAP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = 4'b0000;
                w_id_nxt    = 2'd0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_gnt     <= 4'b0000;
            r_gnt_id  <= 2'd0;
            r_last_id <= 2'd3;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_gnt_id  <= w_id_nxt;
            r_last_id <= w_last_nxt;
            r_cnt     <= w_cnt_nxt;
            r_timeout <= w_to_nxt;
        end
    end

    assign GNT     = r_gnt;
    assign GNT_ID  = r_gnt_id;
    assign BUSY    = |r_gnt;
    assign TIMEOUT = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_req_arbiter_4ch.sv
`default_nettype none
// ============================================================================
// Module   : tb_req_arbiter_4ch
// Brief    : Self-checking bench for req_arbiter_4ch against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_req_arbiter_4ch;

    localparam int c_max_hold = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] REQ = 4'b0000;
    logic       RR_MODE = 1'b0;
    logic       DONE = 1'b0;
    logic [3:0] GNT;
    logic [1:0] GNT_ID;
    logic       BUSY;
    logic       TIMEOUT;

    int checks = 0;
    int errors = 0;

    // Behavioural model: owner index (-1 = none), hold length, dead-time flag.
    int m_owner = -1;
    int m_hold  = 0;
    bit m_gap   = 0;
    int m_last  = 3;
    bit m_to    = 0;

    req_arbiter_4ch #(.MAX_HOLD(c_max_hold)) dut (
        .clk     (clk),
        .rst     (rst),
        .REQ     (REQ),
        .RR_MODE (RR_MODE),
        .DONE    (DONE),
        .GNT     (GNT),
        .GNT_ID  (GNT_ID),
        .BUSY    (BUSY),
        .TIMEOUT (TIMEOUT)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick_winner(input logic [3:0] req, input bit rr, input int last);
        if (rr) begin
            for (int k = 1; k <= 4; k++)
                if (req[(last + k) % 4]) return (last + k) % 4;
        end else begin
            for (int k = 3; k >= 0; k--)
                if (req[k]) return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_hold = 0; m_gap = 0; m_last = 3; m_to = 0;
    endtask

    task automatic model_step();
        bit new_to = 0;
        if (m_owner >= 0) begin
            if (DONE || !REQ[m_owner] || m_hold == c_max_hold) begin
                new_to  = !DONE && REQ[m_owner];
                m_last  = m_owner;
                m_owner = -1;
                m_gap   = 1;
            end else begin
                m_hold++;
            end
        end else if (m_gap) begin
            m_gap = 0;
        end else if (REQ != 4'b0000) begin
            m_owner = pick_winner(REQ, RR_MODE, m_last);
            m_hold  = 1;
        end
        m_to = new_to;
    endtask

    task automatic check_model();
        logic [3:0] exp_gnt;
        exp_gnt = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        chk("gnt", 32'(GNT), 32'(exp_gnt));
        chk("gnt_id", 32'(GNT_ID), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
        chk("busy", 32'(BUSY), 32'(m_owner >= 0));
        chk("timeout", 32'(TIMEOUT), 32'(m_to));
        chk("inv_onehot", 32'($onehot0(GNT)), 32'd1);
        chk("inv_busy", 32'(BUSY), 32'(|GNT));
        if (BUSY) chk("inv_id", 32'(GNT), 32'(4'b0001 << GNT_ID));
    endtask

    // One clock: model sees the same inputs the DUT samples, check #1 later.
    task automatic cycle();
        @(posedge clk);
        if (rst) model_reset(); else model_step();
        #1;
        check_model();
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_gnt", 32'(GNT), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_timeout", 32'(TIMEOUT), 32'd0);
        cycle();
        rst = 1'b0;
        cycle();

        // Fixed priority
        RR_MODE = 1'b0; REQ = 4'b0110;
        cycle();
        chk("fix_gnt", 32'(GNT), 32'h4);
        chk("fix_id", 32'(GNT_ID), 32'd2);
        chk("fix_busy", 32'(BUSY), 32'd1);

        // Release and dead time
        DONE = 1'b1;
        cycle();
        chk("gap1_gnt", 32'(GNT), 32'd0);
        DONE = 1'b0;
        cycle();
        chk("gap2_gnt", 32'(GNT), 32'd0);
        cycle();
        chk("regrant_gnt", 32'(GNT), 32'h4);

        // Owner 2 withdraws in favour of 3
        REQ = 4'b1000;
        repeat (3) cycle();
        chk("own3_gnt", 32'(GNT), 32'h8);

        // Owner 3 withdraws: no timeout, channel 0 after the gap
        REQ = 4'b0001;
        cycle();
        chk("wd_gnt", 32'(GNT), 32'd0);
        chk("wd_timeout", 32'(TIMEOUT), 32'd0);
        cycle();
        chk("wd_gap", 32'(GNT), 32'd0);
        cycle();
        chk("wd_ch0", 32'(GNT), 32'h1);

        // Watchdog: channel 0 already holds for 1 cycle, 3 more before expiry
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("hold_gnt", 32'(GNT), 32'h1);
        end
        cycle();
        chk("to_gnt", 32'(GNT), 32'd0);
        chk("to_pulse", 32'(TIMEOUT), 32'd1);
        cycle();
        chk("to_gap", 32'(GNT), 32'd0);
        chk("to_pulse_end", 32'(TIMEOUT), 32'd0);
        cycle();
        chk("to_regrant", 32'(GNT), 32'h1);

        // Async reset mid-grant
        #3 rst = 1'b1;
        #1;
        model_reset();
        chk("arst_gnt", 32'(GNT), 32'd0);
        chk("arst_busy", 32'(BUSY), 32'd0);
        chk("arst_timeout", 32'(TIMEOUT), 32'd0);
        #2 rst = 1'b0;
        RR_MODE = 1'b1; REQ = 4'b1111;

        // Round-robin rotation 0,1,2,3,0
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("rr_id", 32'(GNT_ID), 32'(k % 4));
            chk("rr_busy", 32'(BUSY), 32'd1);
            DONE = 1'b1;
            cycle();
            DONE = 1'b0;
            cycle();
        end

        // Randomised traffic against the model
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(3) == 0) REQ = 4'($urandom);
            if ($urandom_range(15) == 0) RR_MODE = ~RR_MODE;
            DONE = ($urandom_range(5) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
